// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler that shares one UART transmitter between NUM_REQ
//   parallel-data requesters. It picks a pending requester, acks it, launches
//   its byte with a one-cycle TX_DATA_VALID pulse, then follows the
//   transmitter's Busy through the frame before arbitrating again.
//
// Ports
//   CLK            clock
//   RST            synchronous active-high reset
//   REQ_VALID      per-requester pending flag (bit i = requester i)
//   REQ_DATA       requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   REQ_ACK        one-cycle accept pulse to the granted requester
//   TX_BUSY        Busy from the transmitter
//   TX_P_DATA      byte to the transmitter, held through the frame
//   TX_DATA_VALID  one-cycle launch pulse to the transmitter
//   GRANT_ID       index of the last granted requester
//   CTRL_BUSY      high whenever the FSM is not idle
//   START_ERR      one-cycle pulse when Busy never rose after a launch
//
// Build option
//   UART_TX_ARB_PRIO0_EN: requester 0 becomes strict high priority; the
//   remaining requesters round-robin among themselves.

module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned START_TIMEOUT = 4,
  localparam int unsigned IdW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_ACK,
  input  logic                          TX_BUSY,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  output logic [IdW-1:0]                GRANT_ID,
  output logic                          CTRL_BUSY,
  output logic                          START_ERR
);

  // One extra bit so rr_ptr + k can be wrapped without overflow.
  localparam int unsigned SumW = IdW + 1;
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StWaitStart, StWaitDone} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [IdW-1:0]          rr_ptr_q;
  logic [IdW-1:0]          grant_id_q;
  logic [NUM_REQ-1:0]      req_ack_q;
  logic [DATA_WIDTH-1:0]   tx_p_data_q;
  logic                    tx_data_valid_q;
  logic                    start_err_q;

  logic [NUM_REQ-1:0]      cand;
  logic [SumW-1:0]         sum;
  logic                    win_found;
  logic                    hold_ptr;
  logic [IdW-1:0]          win_idx;
  logic [IdW-1:0]          rr_ptr_d;
  logic [NUM_REQ-1:0]      ack_d;
  logic [DATA_WIDTH-1:0]   win_data;

  // Winner = first candidate found scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin
    cand      = REQ_VALID;
    win_found = 1'b0;
    win_idx   = '0;
    hold_ptr  = 1'b0;
    sum       = '0;
`ifdef UART_TX_ARB_PRIO0_EN
    // Requester 0 is handled separately; the scan only rotates over 1..N-1.
    cand[0]   = 1'b0;
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SumW'(k);
      if (sum >= SumW'(NUM_REQ)) begin
        sum = sum - SumW'(NUM_REQ);
      end
      if (!win_found && cand[sum[IdW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[IdW-1:0];
      end
    end
`ifdef UART_TX_ARB_PRIO0_EN
    // Strict priority win leaves the rotation of the others undisturbed.
    if (REQ_VALID[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
      hold_ptr  = 1'b1;
    end
`endif
    rr_ptr_d = rr_ptr_q;
    if (!hold_ptr) begin
      rr_ptr_d = (win_idx == IdW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
    ack_d          = '0;
    ack_d[win_idx] = 1'b1;
    win_data       = REQ_DATA[win_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      rr_ptr_q        <= '0;
      grant_id_q      <= '0;
      req_ack_q       <= '0;
      tx_p_data_q     <= '0;
      tx_data_valid_q <= 1'b0;
      start_err_q     <= 1'b0;
    end else begin
      // Launch, ack and error are single-cycle pulses by default.
      tx_data_valid_q <= 1'b0;
      req_ack_q       <= '0;
      start_err_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          // A Busy transmitter in idle (external or leftover frame) blocks grants.
          if (!TX_BUSY && win_found) begin
            tx_p_data_q     <= win_data;
            tx_data_valid_q <= 1'b1;
            req_ack_q       <= ack_d;
            grant_id_q      <= win_idx;
            rr_ptr_q        <= rr_ptr_d;
            cnt_q           <= '0;
            state_q         <= StWaitStart;
          end
        end
        StWaitStart: begin
          if (TX_BUSY) begin
            state_q <= StWaitDone;
          end else if (cnt_q == CntW'(START_TIMEOUT - 1)) begin
            // Byte is dropped: it was already acked and is not re-sent.
            start_err_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!TX_BUSY) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign REQ_ACK       = req_ack_q;
  assign TX_P_DATA     = tx_p_data_q;
  assign TX_DATA_VALID = tx_data_valid_q;
  assign GRANT_ID      = grant_id_q;
  assign CTRL_BUSY     = (state_q != StIdle);
  assign START_ERR     = start_err_q;

endmodule
